dbus_sram_responder: RTL and testbench

Data-bus responder for the pipeline's memory stage. It accepts `dbus_req_t` requests and returns `dbus_resp_t` responses, the same `dresp` that write-back consumes for `OP_LW`. The block holds a word-addressed, byte-strobed SRAM model with a programmable response latency. It serves as the simulation and FPGA data memory behind the CPU core and supports one outstanding transaction.

---
 rtl/dbus_sram_responder.sv | 142 ++++++++++++++
 tb/tb_dbus_sram_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: word-addressed, byte-strobed memory with programmable latency, one transaction in flight.
// Optional random stall injection when DBUS_RAND_STALL_EN is defined.
module dbus_sram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dreq_valid_i,
    input  logic [31:0] dreq_addr_i,
    input  logic [2:0]  dreq_size_i,
    input  logic [3:0]  dreq_strobe_i,
    input  logic [31:0] dreq_data_i,
    output logic        dresp_addr_ok_o,
    output logic        dresp_data_ok_o,
    output logic [31:0] dresp_data_o,
    output logic        busy_o
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [4:0]  LAT_C = 5'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   idx_s;
    logic                    accept_s;
    logic                    addr_ok_s;
    logic                    stall_ok_s;
    logic [4:0]              lat_eff_s;
    logic                    unused_s;

    assign idx_s    = dreq_addr_i[DEPTH_LOG2+1:2];
    // Sub-word offset, size and wrap-around bits play no part in addressing.
    assign unused_s = ^{dreq_addr_i[31:DEPTH_LOG2+2], dreq_addr_i[1:0], dreq_size_i, idx_q};

`ifdef DBUS_RAND_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR x^8+x^6+x^5+x^4, free-running
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall_ok_s = lfsr_q[0];
    assign lat_eff_s  = LAT_C + {3'b000, lfsr_q[2:1]};
`else
    assign stall_ok_s = 1'b1;
    assign lat_eff_s  = LAT_C;
`endif

    assign addr_ok_s = (state_q == ST_IDLE) && dreq_valid_i && stall_ok_s && !reset_i;

    // Next-state logic and accept-cycle capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr_ok_s) begin
                    accept_s = 1'b1;
                    idx_d    = idx_s;
                    wr_d     = (dreq_strobe_i != 4'b0000);
                    rdata_d  = mem_q[idx_s];
                    if (lat_eff_s == 5'd1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = lat_eff_s - 5'd2;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane writes commit at the accept edge; contents survive reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (accept_s && dreq_strobe_i[i]) begin
                mem_q[idx_s][8*i +: 8] <= dreq_data_i[8*i +: 8];
            end
        end
    end

    // Reset gates the outputs so a dropped transaction never signals completion.
    assign dresp_addr_ok_o = addr_ok_s;
    assign dresp_data_ok_o = (state_q == ST_RESP) && !reset_i;
    assign dresp_data_o    = (dresp_data_ok_o && !wr_q) ? rdata_q : 32'd0;
    assign busy_o          = (state_q != ST_IDLE) && !reset_i;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: two instances (LATENCY 1 and 4) checked every cycle against a
// transaction-level memory model, plus directed literal expectations.
module tb_dbus_sram_responder;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        valid [2];
    logic [31:0] addr  [2];
    logic [2:0]  size  [2];
    logic [3:0]  strb  [2];
    logic [31:0] wdata [2];
    logic        aok   [2];
    logic        dok   [2];
    logic [31:0] rdata [2];
    logic        busy  [2];

    always #5 clk = ~clk;

    dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(LAT0)) u_dut0 (
        .clk_i(clk), .reset_i(rst[0]), .dreq_valid_i(valid[0]), .dreq_addr_i(addr[0]),
        .dreq_size_i(size[0]), .dreq_strobe_i(strb[0]), .dreq_data_i(wdata[0]),
        .dresp_addr_ok_o(aok[0]), .dresp_data_ok_o(dok[0]), .dresp_data_o(rdata[0]), .busy_o(busy[0])
    );

    dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .reset_i(rst[1]), .dreq_valid_i(valid[1]), .dreq_addr_i(addr[1]),
        .dreq_size_i(size[1]), .dreq_strobe_i(strb[1]), .dreq_data_i(wdata[1]),
        .dresp_addr_ok_o(aok[1]), .dresp_data_ok_o(dok[1]), .dresp_data_o(rdata[1]), .busy_o(busy[1])
    );

    // Reference model: per-instance word memory plus the single outstanding transaction
    logic [31:0] mem_m     [2][1024];
    bit          known_m   [2][1024];
    bit          outst     [2];
    int          age       [2];
    logic [31:0] exp_d     [2];
    bit          exp_known [2];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input int k, input int lat);
        int          mx;
        logic [9:0]  w;
`ifdef DBUS_RAND_STALL_EN
        mx = lat + 3;
`else
        mx = lat;
`endif
        if (rst[k]) begin
            chk("rst_addr_ok", 32'(aok[k]), 32'd0);
            chk("rst_data_ok", 32'(dok[k]), 32'd0);
            chk("rst_data", rdata[k], 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            outst[k] = 1'b0;
        end else begin
            chk("busy", 32'(busy[k]), 32'(outst[k]));
            if (outst[k]) begin
                age[k]++;
                chk("addr_ok_while_busy", 32'(aok[k]), 32'd0);
`ifdef DBUS_RAND_STALL_EN
                if (dok[k] || age[k] == mx)
                    chk("data_ok_window", 32'(dok[k] && age[k] >= lat && age[k] <= mx), 32'd1);
`else
                chk("data_ok_timing", 32'(dok[k]), 32'(age[k] == lat));
`endif
                if (dok[k]) begin
                    if (exp_known[k]) chk("resp_data", rdata[k], exp_d[k]);
                    outst[k] = 1'b0;
                end else begin
                    chk("data_zero_no_resp", rdata[k], 32'd0);
                    if (age[k] >= mx) outst[k] = 1'b0;
                end
            end else begin
                chk("stray_data_ok", 32'(dok[k]), 32'd0);
                chk("data_zero_idle", rdata[k], 32'd0);
`ifdef DBUS_RAND_STALL_EN
                chk("addr_ok_needs_valid", 32'(aok[k] && !valid[k]), 32'd0);
`else
                chk("addr_ok_idle", 32'(aok[k]), 32'(valid[k]));
`endif
                if (valid[k] && aok[k]) begin
                    w = addr[k][11:2];
                    if (strb[k] == 4'b0000) begin
                        exp_d[k]     = mem_m[k][w];
                        exp_known[k] = known_m[k][w];
                    end else begin
                        exp_d[k]     = 32'd0;
                        exp_known[k] = 1'b1;
                        for (int i = 0; i < 4; i++)
                            if (strb[k][i]) mem_m[k][w][8*i +: 8] = wdata[k][8*i +: 8];
                        if (strb[k] == 4'hF) known_m[k][w] = 1'b1;
                    end
                    outst[k] = 1'b1;
                    age[k]   = 0;
                end
            end
        end
    endtask

    task automatic wait_resp(input int k, output logic [31:0] got, output int lat);
        bit ok;
        ok  = 1'b0;
        got = 32'd0;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (dok[k]) begin
                got = rdata[k];
                ok  = 1'b1;
                break;
            end
        end
        chk("response_arrives", 32'(ok), 32'd1);
    endtask

    task automatic send(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] got, output int lat);
        bit ok;
        @(posedge clk);
        #1;
        valid[k] = 1'b1;
        addr[k]  = a;
        strb[k]  = s;
        wdata[k] = d;
        size[k]  = 3'($urandom_range(0, 2));
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (aok[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("request_accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        if (!ok) begin
            got = 32'd0;
            lat = 0;
        end else begin
            wait_resp(k, got, lat);
        end
    endtask

    initial begin
        logic [31:0] got;
        int          lat;
        int          n2;
        int          cnt;
        bit          ok;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; valid[k] = 1'b0; addr[k] = 32'd0; size[k] = 3'd0;
            strb[k] = 4'd0; wdata[k] = 32'd0; outst[k] = 1'b0; age[k] = 0;
            exp_d[k] = 32'd0; exp_known[k] = 1'b0;
            for (int w = 0; w < 1024; w++) begin
                mem_m[k][w] = 32'd0;
                known_m[k][w] = 1'b0;
            end
        end

        fork
            forever begin
                @(negedge clk);
                check_cycle(0, LAT0);
                check_cycle(1, LAT1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // LATENCY=1: write completes with zero data, then read returns it
        send(0, 32'h0000_0010, 4'hF, 32'hDEADBEEF, got, lat);
        chk("wr_resp_data", got, 32'd0);
`ifndef DBUS_RAND_STALL_EN
        chk("wr_latency1", 32'(lat), 32'd1);
`endif
        send(0, 32'h0000_0010, 4'h0, 32'h0, got, lat);
        chk("rd_deadbeef", got, 32'hDEADBEEF);
`ifndef DBUS_RAND_STALL_EN
        chk("rd_latency1", 32'(lat), 32'd1);
`endif

        // Byte strobes merge lanes
        send(0, 32'h0000_0020, 4'hF, 32'h11223344, got, lat);
        send(0, 32'h0000_0020, 4'b0101, 32'hAABBCCDD, got, lat);
        send(0, 32'h0000_0020, 4'h0, 32'h0, got, lat);
        chk("strobe_merge", got, 32'h11BB33DD);

        // Upper address bits wrap, low bits ignored
        send(0, 32'h1000_0004, 4'hF, 32'h0000CAFE, got, lat);
        send(0, 32'h0000_0004, 4'h0, 32'h0, got, lat);
        chk("wrap_read", got, 32'h0000CAFE);
        send(0, 32'h0000_0006, 4'h0, 32'h0, got, lat);
        chk("unaligned_read", got, 32'h0000CAFE);

        // LATENCY=4: request held valid behind an outstanding read
        send(1, 32'h0000_0010, 4'hF, 32'h12345678, got, lat);
        @(posedge clk);
        #1;
        valid[1] = 1'b1; addr[1] = 32'h0000_0010; strb[1] = 4'h0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (aok[1]) begin ok = 1'b1; break; end
        end
        chk("hold_first_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        addr[1] = 32'h0000_0014;
        ok = 1'b0; n2 = 0; lat = 0; got = 32'd0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            n2++;
            if (dok[1]) begin got = rdata[1]; lat = n2; end
            if (aok[1]) begin ok = 1'b1; break; end
        end
        chk("hold_second_accept", 32'(ok), 32'd1);
        chk("lat4_read_data", got, 32'h12345678);
`ifndef DBUS_RAND_STALL_EN
        chk("lat4_latency", 32'(lat), 32'd4);
        chk("hold_accept_cycle", 32'(n2), 32'd5);
`endif
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        wait_resp(1, got, lat);

        // Reset in the WAIT cycle after a write accept
        @(posedge clk);
        #1;
        valid[1] = 1'b1; addr[1] = 32'h0000_0030; strb[1] = 4'hF; wdata[1] = 32'h55AA55AA;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (aok[1]) begin ok = 1'b1; break; end
        end
        chk("reset_test_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        rst[1]   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (dok[1]) cnt++;
        end
        chk("no_data_ok_after_reset", 32'(cnt), 32'd0);
        send(1, 32'h0000_0030, 4'h0, 32'h0, got, lat);
        chk("write_survives_reset", got, 32'h55AA55AA);

        // Random traffic on a small address window, after seeding every word in it
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++)
                send(k, 32'(w) << 2, 4'hF, $urandom, got, lat);
            for (int i = 0; i < 500; i++) begin
                logic [31:0] a;
                logic [3:0]  s;
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                send(k, a, s, $urandom, got, lat);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
